// File: rtl/ifu_prefetch_ysyx.sv
`timescale 1ns/1ps
// ifu_prefetch_ysyx
// Instruction prefetch unit. Sequential 32-bit words are fetched over an
// AXI-lite read channel into a DEPTH-entry FIFO, which is drained by the IDU.
// A redirect (branch/jump/trap target) flushes the FIFO. A read that is
// already in flight is allowed to complete and its data is thrown away.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   redir_valid, redir_pc      redirect request (always accepted), target PC
//   inst, pc_out, inst_err     FIFO head: instruction, its PC, bus error flag
//   inst_valid, inst_ready     FIFO head handshake towards the IDU
//   m_ar*, m_r*                AXI-lite read address / read data channels
//   m_aw*, m_w*, m_b*          AXI-lite write channels, tied off (never used)
//   dbg_state                  current fetch FSM state (0 IDLE, 1 AR, 2 R)
//
// Handshake rule on every valid/ready pair: a transfer happens on the rising
// clock edge where valid and ready are both 1. Once raised, a valid stays
// high with its payload held stable until that transfer. redir_valid has no
// ready and is taken on every edge where it is 1.
module ifu_prefetch_ysyx #(
    parameter int             AW       = 32,
    parameter int             DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_pc,
    output logic [31:0]   inst,
    output logic [AW-1:0] pc_out,
    output logic          inst_err,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [AW-1:0] m_araddr,
    output logic          m_arvalid,
    input  logic          m_arready,
    input  logic [31:0]   m_rdata,
    input  logic [1:0]    m_rresp,
    input  logic          m_rvalid,
    output logic          m_rready,
    output logic [AW-1:0] m_awaddr,
    output logic          m_awvalid,
    input  logic          m_awready,
    output logic [31:0]   m_wdata,
    output logic [3:0]    m_wstrb,
    output logic          m_wvalid,
    input  logic          m_wready,
    input  logic [1:0]    m_bresp,
    input  logic          m_bvalid,
    output logic          m_bready,
    output logic [1:0]    dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW-1:0] fetch_pc_q;
    logic [AW-1:0] ar_addr_q;
    logic          drop_q;
    logic          halt_q;
    logic          arvalid_q;
    logic          rready_q;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   mem_inst_q [DEPTH];
    logic [AW-1:0] mem_pc_q   [DEPTH];
    logic          mem_err_q  [DEPTH];

    logic r_hs;
    logic push;
    logic pop;
    logic inflight;
    logic issue_ok;
    logic rresp_err;

    assign r_hs      = (state_q == S_R) && m_rvalid;
    // A response that arrives with a redirect, or while a stale read is
    // being drained, never reaches the FIFO.
    assign push      = r_hs && !drop_q && !redir_valid;
    assign pop       = inst_valid && inst_ready;
    assign rresp_err = (m_rresp != 2'b00);
    assign inflight  = (state_q != S_IDLE);
    // Counting the in-flight read guarantees a free slot for its response,
    // so a push never sees a full FIFO.
    assign issue_ok  = !halt_q && ((count_q + CW'(inflight)) < CW'(DEPTH));

    // Fetch FSM plus its registered AXI controls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            ar_addr_q  <= RESET_PC;
            drop_q     <= 1'b0;
            halt_q     <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A redirect seen in IDLE only reloads fetch_pc; the
                    // read to the new target starts on the next cycle.
                    if (!redir_valid && issue_ok) begin
                        state_q    <= S_AR;
                        ar_addr_q  <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + AW'(4);
                        arvalid_q  <= 1'b1;
                    end
                end
                S_AR: begin
                    if (m_arready) begin
                        state_q   <= S_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                S_R: begin
                    if (m_rvalid) begin
                        state_q  <= S_IDLE;
                        rready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                end
            endcase

            if (redir_valid) begin
                fetch_pc_q <= redir_pc;
                halt_q     <= 1'b0;
                // An issued AR cannot be withdrawn, so remember to discard
                // its response. If the response completes right now it is
                // already suppressed and nothing stays pending.
                drop_q     <= (state_q == S_AR) || ((state_q == S_R) && !m_rvalid);
            end else begin
                if (r_hs) begin
                    drop_q <= 1'b0;
                end
                // A bus error stops fetch until software redirects.
                if (push && rresp_err) begin
                    halt_q <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redir_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; its contents only matter while inst_valid=1.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst_q[wr_ptr_q] <= m_rdata;
            mem_pc_q[wr_ptr_q]   <= ar_addr_q;
            mem_err_q[wr_ptr_q]  <= rresp_err;
        end
    end

    assign inst       = mem_inst_q[rd_ptr_q];
    assign pc_out     = mem_pc_q[rd_ptr_q];
    assign inst_err   = mem_err_q[rd_ptr_q];
    assign inst_valid = (count_q != '0);

    assign m_araddr  = ar_addr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign dbg_state = state_q;

    // Write channel is never used by instruction fetch
    assign m_awaddr  = '1;
    assign m_awvalid = 1'b0;
    assign m_wdata   = '1;
    assign m_wstrb   = '0;
    assign m_wvalid  = 1'b0;
    assign m_bready  = 1'b0;

    logic unused_write_inputs;
    assign unused_write_inputs = ^{m_awready, m_wready, m_bresp, m_bvalid};

endmodule

// File: tb/tb_ifu_prefetch_ysyx.sv
`timescale 1ns/1ps
module tb_ifu_prefetch_ysyx;

    localparam int          AW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          W        = 65;   // {err, pc, inst}

    logic        clk;
    logic        reset_n;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [1:0]  dbg_state;

    int vectors;
    int miscompares;

    logic [W-1:0]  exp_q[$];     // expected FIFO head entries, in order
    logic [AW-1:0] exp_ar_q[$];  // expected AR addresses, in order

    int          ar_count;
    int          rdelay;
    logic [31:0] err_addr;

    ifu_prefetch_ysyx #(
        .AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .inst(inst), .pc_out(pc_out), .inst_err(inst_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image seen by the slave
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [W-1:0] ent(input logic [31:0] pc, input logic err);
        return {err, pc, mem_word(pc)};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Drivers act 1 time unit after the falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_drained(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && exp_ar_q.size() == 0) return;
            step();
        end
        timeout(name);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        inst_ready  = 1'b0;
        rdelay      = 0;
        err_addr    = '1;
        steps(2);
        check("rst_inst_valid", W'(inst_valid), W'(0));
        check("rst_arvalid", W'(m_arvalid), W'(0));
        check("rst_rready", W'(m_rready), W'(0));
        check("rst_araddr", W'(m_araddr), W'(RESET_PC));
        check("rst_wr_ctrl", W'({m_awvalid, m_wvalid, m_bready, m_wstrb}), W'(0));
        check("rst_wr_data", W'({m_awaddr, m_wdata}), W'(64'hFFFF_FFFF_FFFF_FFFF));
        check("rst_state", W'(dbg_state), W'(0));
        exp_q.delete();
        exp_ar_q.delete();
        ar_count = 0;
        reset_n  = 1'b1;
    endtask

    // AXI-lite read slave: decides its outputs on the falling edge, and
    // commits handshakes that happened on the preceding rising edge.
    initial begin
        logic        s_busy;
        logic        pend_ar;
        logic        pend_r;
        logic [31:0] s_addr;
        int          s_cnt;
        s_busy = 0; pend_ar = 0; pend_r = 0; s_addr = '0; s_cnt = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                s_busy = 0; pend_ar = 0; pend_r = 0;
                m_arready = 0; m_rvalid = 0;
            end else begin
                if (pend_ar) begin
                    s_busy = 1;
                    s_cnt  = rdelay;
                end
                if (pend_r) begin
                    s_busy   = 0;
                    m_rvalid = 0;
                end
                pend_ar = 0;
                pend_r  = 0;
                if (s_busy && !m_rvalid) begin
                    if (s_cnt == 0) begin
                        m_rvalid = 1;
                        m_rdata  = mem_word(s_addr);
                        m_rresp  = (s_addr == err_addr) ? 2'b10 : 2'b00;
                    end else begin
                        s_cnt--;
                    end
                end
                m_arready = !s_busy;
                if (m_arvalid && m_arready) begin
                    pend_ar = 1;
                    s_addr  = m_araddr;
                    ar_count++;
                    if (exp_ar_q.size() > 0) check("ar_addr", W'(m_araddr), W'(exp_ar_q.pop_front()));
                end
                if (m_rvalid && m_rready) pend_r = 1;
            end
        end
    end

    // Monitor: compares every accepted FIFO head against the scoreboard.
    // A head offered in a redirect cycle is flushed, not delivered.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && inst_valid && inst_ready && !redir_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", {inst_err, pc_out, inst}, '0);
                end else begin
                    check("pop", {inst_err, pc_out, inst}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit ok;
        vectors     = 0;
        miscompares = 0;
        ar_count    = 0;
        reset_n     = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        inst_ready  = 1'b0;
        rdelay      = 0;
        err_addr    = '1;

        // 1: sequential fetch, zero-wait slave, IDU always ready
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_ar_q.push_back(RESET_PC + 32'(4 * i));
            exp_q.push_back(ent(RESET_PC + 32'(4 * i), 1'b0));
        end
        wait_drained("t1_drain", 200);
        inst_ready = 1'b0;

        // 2: IDU stalled -> exactly DEPTH reads, then burst drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) exp_ar_q.push_back(RESET_PC + 32'(4 * i));
        steps(40);
        check("t2_ar_count", W'(ar_count), W'(4));
        check("t2_arvalid_idle", W'(m_arvalid), W'(0));
        check("t2_inst_valid", W'(inst_valid), W'(1));
        check("t2_ar_left", W'(exp_ar_q.size()), W'(0));
        exp_q.push_back(ent(32'h8000_0000, 1'b0));
        exp_q.push_back(ent(32'h8000_0004, 1'b0));
        exp_q.push_back(ent(32'h8000_0008, 1'b0));
        exp_q.push_back(ent(32'h8000_000C, 1'b0));
        exp_q.push_back(ent(32'h8000_0010, 1'b0));
        exp_ar_q.push_back(32'h8000_0010);
        inst_ready = 1'b1;
        steps(4);
        check("t2_four_pops", W'(exp_q.size()), W'(1));
        wait_drained("t2_drain", 100);
        inst_ready = 1'b0;

        // 3: redirect while waiting in R with a slow slave
        do_reset();
        rdelay     = 3;
        inst_ready = 1'b1;
        exp_ar_q.push_back(RESET_PC);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_rready && !m_rvalid) begin ok = 1; break; end
            step();
        end
        if (!ok) timeout("t3_wait_r");
        redir_valid = 1'b1;
        redir_pc    = 32'h8000_0100;
        exp_ar_q.push_back(32'h8000_0100);
        exp_ar_q.push_back(32'h8000_0104);
        exp_q.push_back(ent(32'h8000_0100, 1'b0));
        exp_q.push_back(ent(32'h8000_0104, 1'b0));
        step();
        redir_valid = 1'b0;
        check("t3_state_still_r", W'(dbg_state), W'(2));
        check("t3_fifo_empty", W'(inst_valid), W'(0));
        wait_drained("t3_drain", 200);
        inst_ready = 1'b0;

        // 4: redirect together with an R handshake and a pop
        do_reset();
        exp_ar_q.push_back(32'h8000_0000);
        exp_ar_q.push_back(32'h8000_0004);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_rready && m_rvalid && inst_valid) begin ok = 1; break; end
            step();
        end
        if (!ok) timeout("t4_wait_rhs");
        redir_valid = 1'b1;
        redir_pc    = 32'h8000_0200;
        inst_ready  = 1'b1;
        exp_ar_q.push_back(32'h8000_0200);
        exp_ar_q.push_back(32'h8000_0204);
        exp_q.push_back(ent(32'h8000_0200, 1'b0));
        exp_q.push_back(ent(32'h8000_0204, 1'b0));
        step();
        redir_valid = 1'b0;
        check("t4_fifo_flushed", W'(inst_valid), W'(0));
        wait_drained("t4_drain", 100);
        inst_ready = 1'b0;

        // 5: error response halts fetch until a redirect
        do_reset();
        err_addr   = 32'h8000_0008;
        inst_ready = 1'b1;
        exp_ar_q.push_back(32'h8000_0000);
        exp_ar_q.push_back(32'h8000_0004);
        exp_ar_q.push_back(32'h8000_0008);
        exp_q.push_back(ent(32'h8000_0000, 1'b0));
        exp_q.push_back(ent(32'h8000_0004, 1'b0));
        exp_q.push_back(ent(32'h8000_0008, 1'b1));
        wait_drained("t5_drain_err", 100);
        steps(20);
        check("t5_halt_ar_count", W'(ar_count), W'(3));
        check("t5_halt_arvalid", W'(m_arvalid), W'(0));
        check("t5_halt_empty", W'(inst_valid), W'(0));
        err_addr    = '1;
        redir_valid = 1'b1;
        redir_pc    = 32'h8000_0000;
        exp_ar_q.push_back(32'h8000_0000);
        exp_ar_q.push_back(32'h8000_0004);
        exp_q.push_back(ent(32'h8000_0000, 1'b0));
        exp_q.push_back(ent(32'h8000_0004, 1'b0));
        step();
        redir_valid = 1'b0;
        wait_drained("t5_drain_resume", 100);
        inst_ready = 1'b0;

        // 6: asynchronous reset in the middle of a read
        do_reset();
        exp_ar_q.push_back(32'h8000_0000);
        exp_ar_q.push_back(32'h8000_0004);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_arvalid && inst_valid) begin ok = 1; break; end
            step();
        end
        if (!ok) timeout("t6_wait_ar");
        reset_n = 1'b0;
        #1;
        check("t6_async_arvalid", W'(m_arvalid), W'(0));
        check("t6_async_inst_valid", W'(inst_valid), W'(0));
        check("t6_async_state", W'(dbg_state), W'(0));
        steps(2);
        exp_q.delete();
        exp_ar_q.delete();
        ar_count = 0;
        reset_n  = 1'b1;
        inst_ready = 1'b1;
        exp_ar_q.push_back(RESET_PC);
        exp_q.push_back(ent(RESET_PC, 1'b0));
        wait_drained("t6_restart", 100);
        inst_ready = 1'b0;
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
